// File: rtl/rf_writeback.sv
// Write-back arbiter for the integer register file: round-robin between EXU and LSU,
// registered write port, and a forwarding tap. Optional RF_WB_PERF_CNT_EN adds wb_count.
module rf_writeback #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data
`ifdef RF_WB_PERF_CNT_EN
  ,
  output logic [31:0]           wb_count
`endif
);

  logic                  pri_reg, pri_next;
  logic                  grant_exu, grant_lsu;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  wen_reg, wen_next;
  logic [ADDR_WIDTH-1:0] waddr_reg, waddr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;

  // pri=0: EXU wins a tie, pri=1: LSU wins a tie. Grants are suppressed in reset.
  always_comb begin
    grant_exu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst) begin
      if (exu_valid && (!lsu_valid || !pri_reg))
        grant_exu = 1'b1;
      else if (lsu_valid)
        grant_lsu = 1'b1;
    end
  end

  assign exu_ready = grant_exu;
  assign lsu_ready = grant_lsu;
  assign sel_rd    = grant_lsu ? lsu_rd   : exu_rd;
  assign sel_data  = grant_lsu ? lsu_data : exu_data;

  always_comb begin
    pri_next   = pri_reg;
    wen_next   = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    if (grant_exu || grant_lsu) begin
      pri_next = grant_exu;
      // Writes to x0 release the producer but never reach the register file.
      if (sel_rd != '0) begin
        wen_next   = 1'b1;
        waddr_next = sel_rd;
        wdata_next = sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_reg   <= 1'b0;
      wen_reg   <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      pri_reg   <= pri_next;
      wen_reg   <= wen_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
    end
  end

  assign rf_wen   = wen_reg;
  assign rf_waddr = waddr_reg;
  assign rf_wdata = wdata_reg;

  // Covers the cycle before the array holds the value being written.
  assign fwd_hit  = wen_reg && (waddr_reg == rs_addr) && (rs_addr != '0);
  assign fwd_data = wdata_reg;

`ifdef RF_WB_PERF_CNT_EN
  logic [31:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst)
      count_reg <= '0;
    else if (wen_reg)
      count_reg <= count_reg + 32'd1;
  end

  assign wb_count = count_reg;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Randomized + directed bench for rf_writeback: a driver pushes expected writes into a
// scoreboard queue, an independent monitor pops and compares on every rf_wen cycle.
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exu_valid = 1'b0, lsu_valid = 1'b0;
  logic        exu_ready, lsu_ready;
  logic [4:0]  exu_rd = '0, lsu_rd = '0, rs_addr = '0;
  logic [31:0] exu_data = '0, lsu_data = '0;
  logic        rf_wen, fwd_hit;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, fwd_data;
`ifdef RF_WB_PERF_CNT_EN
  logic [31:0] wb_count;
`endif

  rf_writeback #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rs_addr(rs_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`ifdef RF_WB_PERF_CNT_EN
    , .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          grant_log[$];
  int          n_total = 0;
  int          n_pass  = 0;
  bit          mon_en  = 1'b0;
  bit          got_e, got_l;
  logic        last_was_lsu;   // which producer won the most recent handshake
  logic [4:0]  last_rd = '0;
  int unsigned exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: a lone valid wins; on a tie the producer that did not win last time goes.
  task automatic step();
    bit want_e, want_l;
    @(negedge clk);
    want_e = 1'b0;
    want_l = 1'b0;
    if (!rst) begin
      if (exu_valid && lsu_valid) begin
        want_e = last_was_lsu;
        want_l = !last_was_lsu;
      end else begin
        want_e = exu_valid;
        want_l = lsu_valid;
      end
    end
    chk("exu_ready", exu_ready, want_e);
    chk("lsu_ready", lsu_ready, want_l);
    got_e = want_e;
    got_l = want_l;
    if (want_e || want_l) begin
      wr_t w;
      w.addr = want_e ? exu_rd : lsu_rd;
      w.data = want_e ? exu_data : lsu_data;
      grant_log.push_back(int'(w.addr));
      last_rd = w.addr;
      if (w.addr != 5'd0) exp_q.push_back(w);
      last_was_lsu = want_l;
    end
    if (rst) last_was_lsu = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes one expected write for every rf_wen cycle.
  always @(negedge clk) begin
    if (mon_en) begin
`ifdef RF_WB_PERF_CNT_EN
      chk("wb_count", wb_count, exp_cnt);
`endif
      if (rf_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wen", rf_wen, 1'b0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          $display("wb: addr=%0d data=0x%08h rs=%0d hit=%0b", rf_waddr, rf_wdata, rs_addr, fwd_hit);
          chk("rf_waddr", rf_waddr, e.addr);
          chk("rf_wdata", rf_wdata, e.data);
          chk("fwd_data", fwd_data, e.data);
          chk("fwd_hit", fwd_hit, (e.addr == rs_addr) && (rs_addr != 5'd0));
        end
      end else begin
        chk("fwd_hit_idle", fwd_hit, 1'b0);
      end
      if (rst) exp_cnt = 0;
      else if (rf_wen === 1'b1) exp_cnt = exp_cnt + 1;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    last_was_lsu = 1'b1;
    // Reset: readies stay low even with both producers asking.
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h2;
    step();
    mon_en = 1'b1;
    step();
    @(negedge clk);
    chk("reset_wen", rf_wen, 1'b0);
    chk("reset_waddr", rf_waddr, 5'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    lsu_valid = 1'b0;
    step();
    chk("lone_exu_granted", got_e, 1'b1);
    exu_valid = 1'b0;
    step();

    // Both valid: alternation starting with EXU after reset.
    do_reset();
    grant_log.delete();
    exu_valid = 1'b1; exu_rd = 5'd1;  exu_data = 32'hE000_0001;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hA000_000B;
    for (int i = 0; i < 4; i++) begin
      step();
      if (got_e) begin exu_rd = exu_rd + 5'd1; exu_data = exu_data + 32'd1; end
      if (got_l) begin lsu_rd = lsu_rd + 5'd1; lsu_data = lsu_data + 32'd1; end
    end
    exu_valid = 1'b0; lsu_valid = 1'b0;
    chk("order0", grant_log[0], 1);
    chk("order1", grant_log[1], 11);
    chk("order2", grant_log[2], 2);
    chk("order3", grant_log[3], 12);
    step();

    // Single EXU write with forwarding.
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234_5678; rs_addr = 5'd5;
    step();
    exu_valid = 1'b0;
    @(negedge clk);
    chk("exu5_wen", rf_wen, 1'b1);
    chk("exu5_waddr", rf_waddr, 5'd5);
    chk("exu5_fwd_hit", fwd_hit, 1'b1);
    chk("exu5_fwd_data", fwd_data, 32'h1234_5678);
    @(posedge clk); #1;
    @(negedge clk);
    chk("exu5_wen_after", rf_wen, 1'b0);
    @(posedge clk); #1;

    // LSU write to x0: handshake completes, no write, no forward.
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hDEAD_BEEF; rs_addr = 5'd0;
    step();
    chk("x0_lsu_ready", got_l, 1'b1);
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("x0_wen", rf_wen, 1'b0);
    chk("x0_fwd_hit", fwd_hit, 1'b0);
    @(posedge clk); #1;

    // Reset in the same cycle as an EXU request: nothing is written.
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h0BAD_F00D; rst = 1'b1;
    step();
    rst = 1'b0; exu_valid = 1'b0;
    @(negedge clk);
    chk("rst_hs_wen", rf_wen, 1'b0);
    @(posedge clk); #1;

    // Randomized traffic: producers hold valid until accepted; occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      if (!exu_valid && $urandom_range(0, 1) == 1) begin
        exu_valid = 1'b1;
        exu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        exu_data  = $urandom;
      end
      if (!lsu_valid && $urandom_range(0, 1) == 1) begin
        lsu_valid = 1'b1;
        lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        lsu_data  = $urandom;
      end
      rs_addr = ($urandom_range(0, 1) == 1) ? last_rd : 5'($urandom_range(0, 31));
      step();
      if (got_e) exu_valid = 1'b0;
      if (got_l) lsu_valid = 1'b0;
    end
    rst = 1'b0; exu_valid = 1'b0; lsu_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

`ifdef RF_WB_PERF_CNT_EN
    // Ten real writes plus three to x0 give a count of ten.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      exu_valid = 1'b1;
      exu_rd    = (i < 10) ? 5'(i + 1) : 5'd0;
      exu_data  = 32'(i * 7);
      step();
    end
    exu_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("perf_count", wb_count, 32'd10);
    @(posedge clk); #1;
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
